fft_cooley_tukey_helpers_sine_table_loader: RTL and testbench

//  Builds the full-period sine table sine_wave_out[m] = sin(2*pi*m/SIZE_FFT) that feeds the

---
 rtl/fft_cooley_tukey_helpers_sine_table_loader.sv | 132 +++++++++++++
 tb/tb_fft_cooley_tukey_helpers_sine_table_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_cooley_tukey_helpers_sine_table_loader.sv
// rtl/fft_cooley_tukey_helpers_sine_table_loader.sv - quarter-wave to full-period sine table loader
//
// Purpose:
//   Accepts SIZE_FFT/4+1 quarter-wave samples s[k] = sin(2*pi*k/SIZE_FFT) over a val/rdy
//   stream and expands them by symmetry into a registered full-period table of SIZE_FFT
//   entries for the Cooley-Tukey twiddle generator. table_valid is raised once the table
//   is complete; table_reload clears the table and restarts the load.
//
// Ports:
//   clk           in   clock
//   reset         in   synchronous, active-high reset (priority over everything)
//   recv_msg      in   quarter-wave sample, two's complement, BIT_WIDTH bits
//   recv_val      in   recv_msg valid
//   recv_rdy      out  loader accepts a sample this cycle (low while reset is high)
//   table_reload  in   single-cycle pulse: clear table, restart load (beats a handshake)
//   sine_wave_out out  SIZE_FFT x BIT_WIDTH registered sine table
//   table_valid   out  table complete and frozen
//   table_err     out  sticky sample-sanity flag, present only with FFT_SINE_LOADER_CHECK_EN
//
// Configuration macro: FFT_SINE_LOADER_CHECK_EN enables table_err and its checks.

module fft_cooley_tukey_helpers_sine_table_loader #(
  parameter int BIT_WIDTH  = 32,
  parameter int DECIMAL_PT = 16,
  parameter int SIZE_FFT   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] recv_msg,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  input  logic                 table_reload,
  output logic [BIT_WIDTH-1:0] sine_wave_out [SIZE_FFT],
  output logic                 table_valid
`ifdef FFT_SINE_LOADER_CHECK_EN
  ,
  output logic                 table_err
`endif
);

  localparam int QUARTER = SIZE_FFT / 4;
  localparam int KW      = $clog2(QUARTER + 1) + 1;
  localparam int IW      = $clog2(SIZE_FFT);

  if ((SIZE_FFT < 4) || ((SIZE_FFT & (SIZE_FFT - 1)) != 0)) begin : g_bad_size
    $error("SIZE_FFT must be a power of two >= 4");
  end
  if ((DECIMAL_PT < 0) || (DECIMAL_PT >= BIT_WIDTH)) begin : g_bad_point
    $error("DECIMAL_PT must lie within BIT_WIDTH");
  end

  typedef enum logic {
    LOAD = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [KW-1:0]          k_q;
  logic                   accept;
  logic [IW-1:0]          k_idx;
  logic [IW-1:0]          idx_mirror;
  logic [IW-1:0]          idx_neg;
  logic [IW-1:0]          idx_neg_mirror;
  logic [BIT_WIDTH-1:0]   neg_msg;

  always_comb begin
    state_d     = state_q;
    recv_rdy    = 1'b0;
    table_valid = 1'b0;
    accept      = 1'b0;
    case (state_q)
      LOAD: begin
        recv_rdy = !reset;
        // A handshake in the reload cycle is dropped: reload wins.
        accept   = recv_val && !reset && !table_reload;
        if (accept && (k_q == KW'(QUARTER))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        table_valid = 1'b1;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
    if (table_reload) begin
      state_d = LOAD;
    end
  end

  // k never exceeds N/4, so it fits the log2(N)-bit table index directly.
  assign k_idx          = IW'(k_q);
  assign idx_mirror     = IW'(SIZE_FFT / 2) - k_idx;
  assign idx_neg        = IW'(SIZE_FFT / 2) + k_idx;
  // (N - k) % N is just -k in log2(N)-bit arithmetic.
  assign idx_neg_mirror = -k_idx;
  // Modulo-2^BIT_WIDTH negation; the most-negative code maps to itself.
  assign neg_msg        = -recv_msg;

  always_ff @(posedge clk) begin
    if (reset || table_reload) begin
      state_q <= LOAD;
      k_q     <= '0;
      for (int i = 0; i < SIZE_FFT; i++) begin
        sine_wave_out[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        k_q                           <= k_q + KW'(1);
        sine_wave_out[k_idx]          <= recv_msg;
        sine_wave_out[idx_mirror]     <= recv_msg;
        sine_wave_out[idx_neg]        <= neg_msg;
        sine_wave_out[idx_neg_mirror] <= neg_msg;
      end
    end
  end

`ifdef FFT_SINE_LOADER_CHECK_EN
  // Quarter-wave samples must be non-negative and the first one must be exactly zero.
  always_ff @(posedge clk) begin
    if (reset || table_reload) begin
      table_err <= 1'b0;
    end else if (accept && (((k_q == '0) && (recv_msg != '0)) || recv_msg[BIT_WIDTH-1])) begin
      table_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_cooley_tukey_helpers_sine_table_loader.sv
// tb/tb_fft_cooley_tukey_helpers_sine_table_loader.sv - scoreboard bench for the sine table loader
module tb_fft_cooley_tukey_helpers_sine_table_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  msg8;
  logic        val8, rdy8, rl8, tv8;
  logic [7:0]  out8 [8];
  logic [15:0] msg16;
  logic        val16, rdy16, rl16, tv16;
  logic [15:0] out16 [16];
`ifdef FFT_SINE_LOADER_CHECK_EN
  logic        err8, err16;
`endif

  fft_cooley_tukey_helpers_sine_table_loader #(
    .BIT_WIDTH(8), .DECIMAL_PT(6), .SIZE_FFT(8)
  ) dut8 (
    .clk(clk), .reset(reset), .recv_msg(msg8), .recv_val(val8), .recv_rdy(rdy8),
    .table_reload(rl8), .sine_wave_out(out8), .table_valid(tv8)
`ifdef FFT_SINE_LOADER_CHECK_EN
    , .table_err(err8)
`endif
  );

  fft_cooley_tukey_helpers_sine_table_loader #(
    .BIT_WIDTH(16), .DECIMAL_PT(14), .SIZE_FFT(16)
  ) dut16 (
    .clk(clk), .reset(reset), .recv_msg(msg16), .recv_val(val16), .recv_rdy(rdy16),
    .table_reload(rl16), .sine_wave_out(out16), .table_valid(tv16)
`ifdef FFT_SINE_LOADER_CHECK_EN
    , .table_err(err16)
`endif
  );

  typedef struct {
    logic [15:0] t [16];
    int          at;
    bit          full;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_hs;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected tables are given entry 0 first (most significant byte/word first).
  task automatic expect8(input logic [63:0] p, input bit full);
    exp_t e;
    for (int i = 0; i < 16; i++) e.t[i] = '0;
    for (int i = 0; i < 8; i++) e.t[i] = {8'h00, p[63-8*i -: 8]};
    e.at = last_hs;
    e.full = full;
    q8.push_back(e);
  endtask

  task automatic expect16(input logic [255:0] p, input bit full);
    exp_t e;
    for (int i = 0; i < 16; i++) e.t[i] = p[255-16*i -: 16];
    e.at = last_hs;
    e.full = full;
    q16.push_back(e);
  endtask

  // Monitors: on each rising table_valid pop the oldest expectation and compare.
  logic tv8_d = 1'b0;
  always @(negedge clk) begin : mon8
    exp_t e;
    if (tv8 && !tv8_d) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid8: got valid at cycle %0d expected none", cyc);
      end else begin
        e = q8.pop_front();
        chk("valid8_cycle", cyc, e.at);
        if (e.full)
          for (int i = 0; i < 8; i++) chk($sformatf("out8[%0d]", i), {24'h0, out8[i]}, {16'h0, e.t[i]});
      end
    end
    tv8_d <= tv8;
  end

  logic tv16_d = 1'b0;
  always @(negedge clk) begin : mon16
    exp_t e;
    if (tv16 && !tv16_d) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid16: got valid at cycle %0d expected none", cyc);
      end else begin
        e = q16.pop_front();
        chk("valid16_cycle", cyc, e.at);
        if (e.full)
          for (int i = 0; i < 16; i++) chk($sformatf("out16[%0d]", i), {16'h0, out16[i]}, {16'h0, e.t[i]});
      end
    end
    tv16_d <= tv16;
  end

  // Drivers are entered 1 time unit after a rising edge and return likewise.
  task automatic send8(input logic [7:0] s, input int gap);
    bit hs = 0;
    if (gap > 0) begin
      val8 = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    msg8 = s;
    val8 = 1'b1;
    for (int n = 0; n < 50 && !hs; n++) begin
      @(negedge clk);
      hs = rdy8;
      @(posedge clk); #1;
    end
    if (!hs) begin
      checks++; errors++;
      $display("FAIL send8_timeout: got no recv_rdy expected handshake");
    end
    last_hs = cyc;
  endtask

  task automatic send16(input logic [15:0] s);
    bit hs = 0;
    msg16 = s;
    val16 = 1'b1;
    for (int n = 0; n < 50 && !hs; n++) begin
      @(negedge clk);
      hs = rdy16;
      @(posedge clk); #1;
    end
    if (!hs) begin
      checks++; errors++;
      $display("FAIL send16_timeout: got no recv_rdy expected handshake");
    end
    last_hs = cyc;
  endtask

  task automatic check_cleared8(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, {31'h0, tv8}, 32'h0);
    chk({tag, "_rdy"}, {31'h0, rdy8}, 32'h1);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_out8[%0d]", tag, i), {24'h0, out8[i]}, 32'h0);
  endtask

  task automatic reload8();
    val8 = 1'b0;
    rl8 = 1'b1;
    @(posedge clk); #1;
    rl8 = 1'b0;
    check_cleared8("reload");
    @(posedge clk); #1;
  endtask

  task automatic settle();
    val8 = 1'b0;
    val16 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    msg8 = '0; val8 = 1'b0; rl8 = 1'b0;
    msg16 = '0; val16 = 1'b0; rl16 = 1'b0;
    last_hs = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rdy8_in_reset", {31'h0, rdy8}, 32'h0);
    chk("rdy16_in_reset", {31'h0, rdy16}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    check_cleared8("reset");
    chk("valid16_after_reset", {31'h0, tv16}, 32'h0);
`ifdef FFT_SINE_LOADER_CHECK_EN
    chk("err16_after_reset", {31'h0, err16}, 32'h0);
`endif
    @(posedge clk); #1;

    // 1: back-to-back load, valid exactly one cycle after the third handshake.
    send8(8'h00, 0); send8(8'h2D, 0); send8(8'h40, 0);
    expect8(64'h00_2D_40_2D_00_D3_C0_D3, 1'b1);
    @(negedge clk);
    chk("rdy8_done_val_high", {31'h0, rdy8}, 32'h0);
    @(posedge clk); #1;
    settle();
    @(negedge clk);
    chk("rdy8_done", {31'h0, rdy8}, 32'h0);
    chk("valid8_held", {31'h0, tv8}, 32'h1);
    @(posedge clk); #1;

    // 3: reload from DONE clears the table, then a different load.
    reload8();
    send8(8'h00, 0); send8(8'h10, 0); send8(8'h20, 0);
    expect8(64'h00_10_20_10_00_F0_E0_F0, 1'b1);
    settle();

    // 2: same samples as test 1 with random gaps.
    reload8();
    send8(8'h00, $urandom_range(0, 3));
    send8(8'h2D, $urandom_range(0, 3));
    send8(8'h40, $urandom_range(0, 3));
    expect8(64'h00_2D_40_2D_00_D3_C0_D3, 1'b1);
    settle();

    // 4: reload coinciding with the second handshake drops that sample.
    reload8();
    send8(8'h11, 0);
    msg8 = 8'h7F; val8 = 1'b1; rl8 = 1'b1;
    @(posedge clk); #1;
    rl8 = 1'b0;
    send8(8'h00, 0); send8(8'h2D, 0); send8(8'h40, 0);
    expect8(64'h00_2D_40_2D_00_D3_C0_D3, 1'b1);
    settle();

    // 5: reset mid-load returns everything to reset values.
    reload8();
    send8(8'h11, 0);
    val8 = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rdy8_midreset", {31'h0, rdy8}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    check_cleared8("midreset");
    @(posedge clk); #1;
    send8(8'h00, 0); send8(8'h2D, 0); send8(8'h40, 0);
    expect8(64'h00_2D_40_2D_00_D3_C0_D3, 1'b1);
    settle();

    // Most-negative sample negates to itself.
    reload8();
    send8(8'h00, 0); send8(8'h80, 0); send8(8'h7F, 0);
    expect8(64'h00_80_7F_80_00_80_81_80, 1'b1);
    settle();

    // 6: 16-point table, then a load with a nonzero first sample.
    send16(16'h0000); send16(16'h187E); send16(16'h2D41); send16(16'h3B21); send16(16'h4000);
    expect16({16'h0000, 16'h187E, 16'h2D41, 16'h3B21, 16'h4000, 16'h3B21, 16'h2D41, 16'h187E,
              16'h0000, 16'hE782, 16'hD2BF, 16'hC4DF, 16'hC000, 16'hC4DF, 16'hD2BF, 16'hE782}, 1'b1);
    settle();
`ifdef FFT_SINE_LOADER_CHECK_EN
    @(negedge clk);
    chk("err16_good_table", {31'h0, err16}, 32'h0);
    @(posedge clk); #1;
`endif
    rl16 = 1'b1;
    @(posedge clk); #1;
    rl16 = 1'b0;
    @(negedge clk);
    chk("valid16_after_reload", {31'h0, tv16}, 32'h0);
    @(posedge clk); #1;
    send16(16'h0001); send16(16'h187E); send16(16'h2D41); send16(16'h3B21); send16(16'h4000);
    expect16('0, 1'b0);
    settle();
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("valid16_bad_table", {31'h0, tv16}, 32'h1);
    chk("out16[4]_bad_table", {16'h0, out16[4]}, 32'h4000);
`ifdef FFT_SINE_LOADER_CHECK_EN
    chk("err16_sticky", {31'h0, err16}, 32'h1);
`endif
    @(posedge clk); #1;

    repeat (2) begin @(posedge clk); #1; end
    chk("q8_drained", q8.size(), 0);
    chk("q16_drained", q16.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
